// File: rtl/e_muldiv_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode encoding,
// default latencies and the HI/LO result payload.
package e_muldiv_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MD_OP_W         = 4;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } md_result_t;

    // Opcodes that launch a multi-cycle operation
    function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_mul(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/e_muldiv_unit_md_arith.sv
// Combinational HI/LO result for mult/multu/div/divu; a zero divisor selects
// the current HI/LO so the architectural registers are left untouched.
module e_muldiv_unit_md_arith
    import e_muldiv_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [XLEN-1:0]    rs,
    input  logic [XLEN-1:0]    rt,
    input  md_result_t         cur,
    output md_result_t         res_c
);

    logic [2*XLEN-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic [XLEN-1:0]   rt_nz, a_mag, b_mag, b_mag_nz;
    logic [XLEN-1:0]   uq, ur, sq, sr, q_s, r_s;
    logic              a_neg, b_neg;

    always_comb begin
        a_sx   = {{XLEN{rs[XLEN-1]}}, rs};
        b_sx   = {{XLEN{rt[XLEN-1]}}, rt};
        a_zx   = {XLEN'(0), rs};
        b_zx   = {XLEN'(0), rt};
        prod_s = a_sx * b_sx;
        prod_u = a_zx * b_zx;

        // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case
        a_neg    = rs[XLEN-1];
        b_neg    = rt[XLEN-1];
        a_mag    = a_neg ? XLEN'(~rs + XLEN'(1)) : rs;
        b_mag    = b_neg ? XLEN'(~rt + XLEN'(1)) : rt;
        rt_nz    = (rt == '0) ? XLEN'(1) : rt;
        b_mag_nz = (b_mag == '0) ? XLEN'(1) : b_mag;
        uq       = rs / rt_nz;
        ur       = rs % rt_nz;
        sq       = a_mag / b_mag_nz;
        sr       = a_mag % b_mag_nz;
        q_s      = (a_neg ^ b_neg) ? XLEN'(~sq + XLEN'(1)) : sq;
        r_s      = a_neg ? XLEN'(~sr + XLEN'(1)) : sr;

        res_c = cur;
        case (op)
            MD_MULT:  res_c = md_result_t'(prod_s);
            MD_MULTU: res_c = md_result_t'(prod_u);
            MD_DIV:   if (rt != '0) res_c = '{hi: r_s, lo: q_s};
            MD_DIVU:  if (rt != '0) res_c = '{hi: ur, lo: uq};
            default:  res_c = cur;
        endcase
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit: owns HI/LO, sequences multi-cycle operations
// with a down-counter and requests D-stage stalls while one is in flight.
module e_muldiv_unit
    import e_muldiv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [XLEN-1:0]    rs_val,
    input  logic [XLEN-1:0]    rt_val,
    input  logic               d_is_md,
    output logic               busy,
    output logic               md_stall,
    output logic [XLEN-1:0]    muldivRes_E,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    md_result_t       pend_q, pend_d, arith_res;
    logic             start_c;

    e_muldiv_unit_md_arith u_md_arith (
        .op    (md_op),
        .rs    (rs_val),
        .rt    (rt_val),
        .cur   ('{hi: hi_q, lo: lo_q}),
        .res_c (arith_res)
    );

    assign busy    = (cnt_q != '0);
    assign start_c = md_is_start(md_op) && !busy;

    // Result is captured at start and committed to HI/LO on the last busy edge
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (busy) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d  = pend_q.hi;
                lo_d  = pend_q.lo;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start_c) begin
            pend_d = arith_res;
            cnt_d  = md_is_mul(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
        end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        md_stall    = d_is_md && (start_c || busy);
        muldivRes_E = '0;
        if (md_op == MD_MFHI)      muldivRes_E = hi_q;
        else if (md_op == MD_MFLO) muldivRes_E = lo_q;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Self-checking bench for e_muldiv_unit: directed test-plan cases followed by
// random operation streams, all compared against an arithmetic reference model.
module tb_e_muldiv_unit;
    import e_muldiv_unit_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        d_is_md = 1'b0;
    logic        busy, md_stall;
    logic [31:0] muldivRes_E, hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 1'b0;
    logic last_busy, last_stall;

    // Reference state: architectural HI/LO, cycles left until commit, queued result
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;

    e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
        .d_is_md(d_is_md), .busy(busy), .md_stall(md_stall),
        .muldivRes_E(muldivRes_E), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_is_start(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd4;
    endfunction

    // Expected HI/LO from plain 64-bit integer arithmetic
    task automatic ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] nh, output logic [31:0] nl);
        longint sa, sb, q, r, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        nh = m_hi;
        nl = m_lo;
        case (op)
            4'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
            4'd2: begin pu = 64'(a) * 64'(b); nh = pu[63:32]; nl = pu[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
            4'd4: if (b != 0) begin nh = a % b; nl = a / b; end
            default: ;
        endcase
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic rst);
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; p_hi = '0; p_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (ref_is_start(op)) begin
            ref_calc(op, a, b, p_hi, p_lo);
            m_left = (op <= 4'd2) ? int'(MC) : int'(DC);
        end else if (op == 4'd5) begin
            m_hi = a;
        end else if (op == 4'd6) begin
            m_lo = a;
        end
    endtask

    // One clock: drive, check mid-cycle, advance model at the edge
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic rst);
        logic        mb;
        logic [31:0] er;
        md_op = op; rs_val = a; rt_val = b; d_is_md = dmd; reset = rst;
        @(negedge clk);
        last_busy  = busy;
        last_stall = md_stall;
        if (chk_on) begin
            mb = (m_left != 0);
            er = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
            check("busy", 32'(busy), 32'(mb));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("md_stall", 32'(md_stall), 32'(dmd && ((ref_is_start(op) && !mb) || mb)));
            check("muldivRes_E", muldivRes_E, er);
        end
        @(posedge clk);
        model_edge(op, a, b, rst);
        #1;
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) step(4'd0, 32'h0, 32'h0, dmd, 1'b0);
    endtask

    initial begin
        int bc, sc;
        logic [3:0]  op;
        logic [31:0] a, b;

        step(4'd0, 0, 0, 0, 1'b1);
        step(4'd0, 0, 0, 0, 1'b1);
        chk_on = 1'b1;
        step(4'd7, 0, 0, 0, 1'b0);
        check("reset_res", muldivRes_E, 32'h0);

        // MULT -2 * 3: busy for exactly MC cycles, stall tracks busy
        step(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        check("stall_start", 32'(last_stall), 32'd1);
        bc = 0; sc = 0;
        for (int i = 0; i < MC + 3; i++) begin
            step(4'd0, 0, 0, 1'b1, 1'b0);
            bc += int'(last_busy);
            sc += int'(last_stall);
        end
        check("mult_busy_cycles", 32'(bc), 32'(MC));
        check("mult_stall_cycles", 32'(sc), 32'(MC));
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        step(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        sc = 0;
        for (int i = 0; i < MC + 1; i++) begin
            step(4'd0, 0, 0, 1'b0, 1'b0);
            sc += int'(last_stall);
        end
        check("multu_nostall", 32'(sc), 32'd0);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        // DIV -7 / 2, with an mflo issued in the cycle right after busy falls
        step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        bc = 0;
        for (int i = 0; i < DC; i++) begin
            step(4'd0, 0, 0, 1'b0, 1'b0);
            bc += int'(last_busy);
        end
        check("div_busy_cycles", 32'(bc), 32'(DC));
        step(4'd8, 0, 0, 1'b0, 1'b0);
        check("div_mflo", muldivRes_E, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        step(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        check("divu0_hi", hi, 32'hFFFFFFFF);
        check("divu0_lo", lo, 32'hFFFFFFFD);

        step(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        idle(DC + 1, 1'b0);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h0);

        // MTHI then MFHI; MTLO while busy is dropped
        step(4'd5, 32'h12345678, 0, 1'b0, 1'b0);
        step(4'd7, 0, 0, 1'b0, 1'b0);
        check("mthi_mfhi", muldivRes_E, 32'h12345678);
        step(4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
        step(4'd6, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        check("mtlo_busy", lo, 32'h80000000);
        idle(MC, 1'b0);
        check("mtlo_after", lo, 32'h1);

        // Reset in the third busy cycle of a DIV aborts it
        step(4'd5, 32'hCAFEF00D, 0, 1'b0, 1'b0);
        step(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(4'd0, 0, 0, 1'b0, 1'b1);
        idle(DC + 2, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);

        // Random streams including ops issued while busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 2) == 0) op = 4'd0;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h1);
            if ($urandom_range(0, 15) == 0) a = 32'h80000000;
            step(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
